// File: rtl/div_hilo_sequencer.sv
// div_hilo_sequencer: multi-cycle signed divider and owner of the HI/LO registers.
// A restoring divider runs on operand magnitudes and produces one quotient bit per cycle.
// A single FIX cycle restores the signs or substitutes the divide-by-zero result.
// HI/LO are written only on the FIX->DONE edge.
// Stall_Req holds a dependent mfhi or a second div in ID until HI/LO are valid.
module div_hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             ID_Mfhi,
    input  logic             ID_Div,
    output logic             Stall_Req,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   ZERO_R = {(WIDTH+1){1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negation, wrapping at WIDTH bits.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = (~v) + ONE_W;
    endfunction

    // Unsigned magnitude of a signed operand; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
        mag_w = v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             zflag_q;
    logic             busy_q;
    logic             done_q;
    logic             divzero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    // One restoring iteration: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        trial_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, dsr_q};
        rem_d   = trial_s;
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        if (trial_s >= {1'b0, dsr_q}) begin
            rem_d = diff_s;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = trial_s;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer FSM, datapath registers and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= CNT_ZERO;
            rem_q     <= ZERO_R;
            quo_q     <= ZERO_W;
            dsr_q     <= ZERO_W;
            dvd_raw_q <= ZERO_W;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            zflag_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                    if (Start) begin
                        quo_q     <= mag_w(Dividend);
                        dsr_q     <= mag_w(Divisor);
                        dvd_raw_q <= Dividend;
                        qsign_q   <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                        rsign_q   <= Dividend[WIDTH-1];
                        rem_q     <= ZERO_R;
                        count_q   <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        if (Divisor == ZERO_W) begin
                            zflag_q <= 1'b1;
                            state_q <= S_FIX;
                        end else begin
                            zflag_q <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_FIX: begin
                    if (zflag_q) begin
                        lo_q <= {WIDTH{1'b1}};
                        hi_q <= dvd_raw_q;
                    end else begin
                        lo_q <= qsign_q ? neg_w(quo_q) : quo_q;
                        hi_q <= rsign_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                    end
                    done_q    <= 1'b1;
                    divzero_q <= zflag_q;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // The hazard unit needs the stall in the same cycle div issues, so this term stays combinational.
    assign Stall_Req = (ID_Mfhi | ID_Div) &
                       ((Start & (state_q == S_IDLE)) | (state_q == S_RUN) | (state_q == S_FIX));

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Directed self-checking bench for div_hilo_sequencer (WIDTH=32).
module tb_div_hilo_sequencer;

    logic        clock;
    logic        reset;
    logic        Start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        ID_Mfhi;
    logic        ID_Div;
    logic        Stall_Req;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fail;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    div_hilo_sequencer #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .ID_Mfhi   (ID_Mfhi),
        .ID_Div    (ID_Div),
        .Stall_Req (Stall_Req),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one divide in cycle 0 and follow it to Done, checking stall, timing and results.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_z, input int exp_cyc,
                           input logic mfhi, input logic iddiv);
        int done_cyc;
        done_cyc = -1;
        check_val("idle_before_start", {31'b0, Busy}, 32'd0);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        ID_Mfhi  = mfhi;
        ID_Div   = iddiv;
        @(negedge clock);
        check_val("stall_c0", {31'b0, Stall_Req}, {31'b0, (mfhi | iddiv)});
        @(posedge clock);
        #1;
        Start    = 1'b0;
        Dividend = 32'hDEADBEEF;
        Divisor  = 32'h0BADF00D;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clock);
            if (c == 1) check_val("busy_c1", {31'b0, Busy}, 32'd1);
            check_val("stall", {31'b0, Stall_Req},
                      {31'b0, ((mfhi | iddiv) && (c < exp_cyc))});
            if (Done) begin
                done_cyc = c;
                check_val("lo", LO, exp_lo);
                check_val("hi", HI, exp_hi);
                check_val("divzero", {31'b0, DivZero}, {31'b0, exp_z});
            end else if (c == exp_cyc - 1) begin
                check_val("hi_hold", HI, model_hi);
                check_val("lo_hold", LO, model_lo);
            end
            @(posedge clock);
            #1;
        end
        check_val("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        ID_Mfhi  = 1'b0;
        ID_Div   = 1'b0;
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(negedge clock);
        check_val("done_pulse_end", {30'b0, Done, Busy}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_fail   = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset    = 1'b1;
        Start    = 1'b0;
        Dividend = 32'd0;
        Divisor  = 32'd0;
        ID_Mfhi  = 1'b0;
        ID_Div   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_status", {28'b0, Busy, Done, DivZero, Stall_Req}, 32'd0);
        check_val("rst_hi", HI, 32'd0);
        check_val("rst_lo", LO, 32'd0);
        @(posedge clock);
        #1;

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0, 1'b0);
        run_div(-32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 1'b0, 1'b0);
        run_div(32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0, 34, 1'b0, 1'b0);
        run_div(-32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE, 1'b0, 34, 1'b0, 1'b0);
        run_div(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2, 1'b0, 1'b0);
        run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34, 1'b0, 1'b0);
        run_div(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 34, 1'b1, 1'b0);
        run_div(32'd77, 32'd10, 32'd7, 32'd7, 1'b0, 34, 1'b0, 1'b1);

        // Reset in cycle 10 of a divide: aborts with no result and no Done pulse.
        Dividend = 32'd100;
        Divisor  = 32'd7;
        Start    = 1'b1;
        @(posedge clock);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("abort_busy", {31'b0, Busy}, 32'd0);
        check_val("abort_done", {31'b0, Done}, 32'd0);
        check_val("abort_hi", HI, 32'd0);
        check_val("abort_lo", LO, 32'd0);
        model_hi  = 32'd0;
        model_lo  = 32'd0;
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (Done) done_seen++;
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);
        @(posedge clock);
        #1;
        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
